// File: rtl/life_pkg.sv
// Shared types and defaults for the Game-of-Life generation controller.
package life_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } life_state_t;

    // Speed code n divides the base period by 4**n.
    typedef enum logic [1:0] {
        SPD_X1  = 2'd0,
        SPD_X4  = 2'd1,
        SPD_X16 = 2'd2,
        SPD_X64 = 2'd3
    } life_speed_t;

    localparam int unsigned TICK_BASE_DEF   = 50_000_000;
    localparam int unsigned LOAD_CYCLES_DEF = 1;
    localparam int unsigned GEN_W           = 16;

    function automatic logic [31:0] period(input logic [31:0] base, input logic [1:0] spd);
        logic [31:0] p;
        p = base >> (2 * spd);
        return (p == '0) ? 32'd1 : p;
    endfunction

endpackage

// File: rtl/life_ctrl_edge_detect.sv
// Registered rising-edge detector: rise is high for one cycle, one cycle after din is first sampled high.
module edge_detect
    import life_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            prev <= din;
            rise <= din & ~prev;
        end
    end

endmodule

// File: rtl/life_ctrl.sv
// Generation controller for a Life cell array: load strobe, run/pause/step, speed divider.
// Optional still-life detection is enabled with `define LIFE_STILL_DETECT_EN.
module life_ctrl
    import life_pkg::*;
#(
    parameter int unsigned TICK_BASE   = TICK_BASE_DEF,
    parameter int unsigned LOAD_CYCLES = LOAD_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_req,
    input  logic             run,
    input  logic             step,
    input  logic [1:0]       speed,
    input  logic             grid_changed,
    output logic             load,
    output logic             gen_en,
    output logic [GEN_W-1:0] gen_count,
    output logic [1:0]       state,
    output logic             stable
);

    life_state_t st;
    logic        load_rise;
    logic        step_rise;
    logic [1:0]  speed_q;
    logic [31:0] div;
    logic [31:0] load_left;
    logic [31:0] per;
    logic        still;
    logic        stable_r;

    edge_detect u_load_edge (.clk(clk), .reset(reset), .din(load_req), .rise(load_rise));
    edge_detect u_step_edge (.clk(clk), .reset(reset), .din(step),     .rise(step_rise));

    assign per    = period(TICK_BASE, speed);
    assign state  = st;
    assign stable = stable_r;

`ifdef LIFE_STILL_DETECT_EN
    // grid_changed reflects the generation advanced by the previous gen_en pulse.
    logic gen_en_q;

    always_ff @(posedge clk) begin
        if (!reset) gen_en_q <= 1'b0;
        else        gen_en_q <= gen_en;
    end

    assign still = gen_en_q & ~grid_changed;
`else
    logic unused_grid;
    assign unused_grid = grid_changed;
    assign still       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            st        <= ST_IDLE;
            load      <= 1'b0;
            gen_en    <= 1'b0;
            gen_count <= '0;
            stable_r  <= 1'b0;
            div       <= '0;
            load_left <= '0;
            speed_q   <= '0;
        end else begin
            load    <= 1'b0;
            gen_en  <= 1'b0;
            speed_q <= speed;
            if (load_rise) begin
                st        <= ST_LOAD;
                load      <= 1'b1;
                load_left <= LOAD_CYCLES - 32'd1;
                div       <= '0;
                gen_count <= '0;
                stable_r  <= 1'b0;
            end else begin
                case (st)
                    ST_IDLE: begin
                    end
                    ST_LOAD: begin
                        if (load_left != '0) begin
                            load      <= 1'b1;
                            load_left <= load_left - 32'd1;
                        end else begin
                            st <= ST_PAUSE;
                        end
                    end
                    ST_PAUSE: begin
                        if (run) begin
                            st  <= ST_RUN;
                            div <= '0;
                        end else if (step_rise) begin
                            gen_en    <= 1'b1;
                            gen_count <= gen_count + 1'b1;
                            stable_r  <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        // A still pattern stops the run before any further tick is issued.
                        if (!run || still) begin
                            st  <= ST_PAUSE;
                            div <= '0;
                        end else if (speed != speed_q) begin
                            div <= '0;
                        end else if (div >= per - 32'd1) begin
                            gen_en    <= 1'b1;
                            gen_count <= gen_count + 1'b1;
                            stable_r  <= 1'b0;
                            div       <= '0;
                        end else begin
                            div <= div + 32'd1;
                        end
                    end
                    default: st <= ST_IDLE;
                endcase
                if (still) stable_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_life_ctrl.sv
// Self-checking bench for life_ctrl: directed scenarios plus random stimulus against a behavioural model.
module tb_life_ctrl;

    localparam int unsigned TB_BASE = 16;
    localparam int unsigned TB_LC   = 2;
`ifdef LIFE_STILL_DETECT_EN
    localparam bit STILL_EN = 1'b1;
`else
    localparam bit STILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, load_req, run, step, grid_changed;
    logic [1:0]  speed;
    logic        load, gen_en, stable;
    logic [15:0] gen_count;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;
    int n;
    bit found;

    life_ctrl #(.TICK_BASE(TB_BASE), .LOAD_CYCLES(TB_LC)) dut (
        .clk(clk), .reset(reset), .load_req(load_req), .run(run), .step(step),
        .speed(speed), .grid_changed(grid_changed), .load(load), .gen_en(gen_en),
        .gen_count(gen_count), .state(state), .stable(stable)
    );

    always #5 clk = ~clk;

    // Reference model: state 0=IDLE 1=LOAD 2=RUN 3=PAUSE; elapsed counts cycles since the period restarted.
    int          m_state;
    bit          m_load, m_gen, m_gen_prev, m_stable;
    logic [15:0] m_count;
    int unsigned m_elapsed, m_load_left;
    bit          lr_last, lr_pending, st_last, st_pending;
    logic [1:0]  m_speed;

    function automatic int unsigned period_of(input logic [1:0] s);
        int unsigned p;
        p = TB_BASE / (4 ** s);
        return (p == 0) ? 1 : p;
    endfunction

    task automatic model_step();
        bit load_ev, step_ev, still, speed_moved;
        if (!reset) begin
            m_state = 0; m_load = 0; m_gen = 0; m_gen_prev = 0; m_stable = 0; m_count = '0;
            m_elapsed = 0; m_load_left = 0;
            lr_last = 0; lr_pending = 0; st_last = 0; st_pending = 0; m_speed = '0;
            return;
        end
        load_ev    = lr_pending;
        step_ev    = st_pending;
        lr_pending = load_req && !lr_last;
        lr_last    = load_req;
        st_pending = step && !st_last;
        st_last    = step;
        still       = STILL_EN && m_gen_prev && !grid_changed;
        m_gen_prev  = m_gen;
        speed_moved = (speed != m_speed);
        m_speed     = speed;
        m_gen  = 0;
        m_load = 0;
        if (load_ev) begin
            m_state = 1; m_load = 1; m_load_left = TB_LC - 1;
            m_count = '0; m_stable = 0; m_elapsed = 0;
        end else begin
            if (m_state == 1) begin
                if (m_load_left > 0) begin m_load = 1; m_load_left--; end
                else m_state = 3;
            end else if (m_state == 3) begin
                if (run) begin m_state = 2; m_elapsed = 0; end
                else if (step_ev) begin m_gen = 1; m_count = m_count + 16'd1; m_stable = 0; end
            end else if (m_state == 2) begin
                if (!run || still) begin m_state = 3; m_elapsed = 0; end
                else if (speed_moved) m_elapsed = 0;
                else begin
                    m_elapsed++;
                    if (m_elapsed == period_of(speed)) begin
                        m_gen = 1; m_count = m_count + 16'd1; m_stable = 0; m_elapsed = 0;
                    end
                end
            end
            if (still) m_stable = 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("state",     32'(state),     32'(m_state));
        check("load",      32'(load),      32'(m_load));
        check("gen_en",    32'(gen_en),    32'(m_gen));
        check("gen_count", 32'(gen_count), 32'(m_count));
        check("stable",    32'(stable),    32'(m_stable));
        if (load === 1'b1 && gen_en === 1'b1) check("load_and_gen", 32'd1, 32'd0);
    endtask

    task automatic measure(input int unsigned p, input string tag);
        int idx[$];
        for (int c = 0; c < 200 && idx.size() < 3; c++) begin
            tick();
            if (gen_en === 1'b1) idx.push_back(c);
        end
        if (idx.size() < 3) check({tag, "_timeout"}, 32'(idx.size()), 32'd3);
        else                check(tag, 32'(idx[2] - idx[1]), 32'(p));
    endtask

    task automatic do_load();
        load_req = 1'b1;
        repeat (6) tick();
        load_req = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0; load_req = 1'b0; run = 1'b0; step = 1'b0; speed = 2'd0; grid_changed = 1'b1;
        repeat (3) tick();
        check("reset_state", 32'(state), 32'd0);
        check("reset_count", 32'(gen_count), 32'd0);
        reset = 1'b1;
        run = 1'b1; step = 1'b1;
        repeat (4) tick();
        check("idle_ignores_run_step", 32'(state), 32'd0);
        run = 1'b0; step = 1'b0;
        tick();

        // Pattern load: two load cycles then PAUSE.
        load_req = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (load === 1'b1) n++;
        end
        check("load_len", 32'(n), 32'd2);
        check("load_to_pause", 32'(state), 32'd3);
        check("load_count", 32'(gen_count), 32'd0);
        load_req = 1'b0;
        tick();

        // Three step edges, step held high for several cycles each.
        n = 0;
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            for (int i = 0; i < 4; i++) begin tick(); if (gen_en === 1'b1) n++; end
            step = 1'b0;
            for (int i = 0; i < 2; i++) begin tick(); if (gen_en === 1'b1) n++; end
        end
        check("step_pulses", 32'(n), 32'd3);
        check("step_count", 32'(gen_count), 32'd3);

        // Free run across all speed settings.
        speed = 2'd0; run = 1'b1;
        measure(16, "period_s0");
        speed = 2'd1; measure(4, "period_s1");
        speed = 2'd2; measure(1, "period_s2");
        speed = 2'd3; measure(1, "period_s3");

        // Load edge acted on at the same edge as a terminal count.
        speed = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (m_state == 2 && m_elapsed == TB_BASE - 2) found = 1'b1;
        end
        check("term_reached", 32'(found), 32'd1);
        load_req = 1'b1;
        tick();
        tick();
        check("term_no_gen", 32'(gen_en), 32'd0);
        check("term_load", 32'(load), 32'd1);
        check("term_count", 32'(gen_count), 32'd0);
        run = 1'b0;
        load_req = 1'b0;
        repeat (4) tick();

        // gen_count wraps: fast run to 0xFFFF, pause, then one step.
        speed = 2'd3; run = 1'b1;
        for (int i = 0; i < 70000 && m_count != 16'hFFFF; i++) tick();
        run = 1'b0;
        tick(); tick();
        check("pre_wrap_count", 32'(gen_count), 32'h0000_FFFF);
        check("pre_wrap_state", 32'(state), 32'd3);
        step = 1'b1;
        tick(); tick();
        check("wrap_count", 32'(gen_count), 32'd0);
        step = 1'b0;
        tick();

        // Still pattern while running.
        do_load();
        speed = 2'd0; grid_changed = 1'b0; run = 1'b1;
        n = 0;
        for (int i = 0; i < 60; i++) begin tick(); if (gen_en === 1'b1) n++; end
        if (STILL_EN) begin
            check("still_pulses", 32'(n), 32'd1);
            check("still_stable", 32'(stable), 32'd1);
            check("still_state", 32'(state), 32'd3);
        end else begin
            check("still_pulses", 32'(n), 32'd3);
            check("still_stable", 32'(stable), 32'd0);
            check("still_state", 32'(state), 32'd2);
        end
        grid_changed = 1'b1; run = 1'b0;
        tick();

        // Reset mid-RUN and mid-LOAD.
        do_load();
        speed = 2'd1; run = 1'b1;
        repeat (10) tick();
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (gen_en === 1'b1 || load === 1'b1) n++; end
        check("rst_run_quiet", 32'(n), 32'd0);
        check("rst_run_state", 32'(state), 32'd0);
        reset = 1'b1; run = 1'b0;
        tick();
        load_req = 1'b1;
        tick(); tick();
        check("mid_load_active", 32'(load), 32'd1);
        reset = 1'b0;
        tick();
        check("rst_load_quiet", 32'(load), 32'd0);
        check("rst_load_state", 32'(state), 32'd0);
        reset = 1'b1; load_req = 1'b0;
        tick();

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(199) != 0);
            if ($urandom_range(39) == 0) load_req = ~load_req;
            if ($urandom_range(29) == 0) run = ~run;
            if ($urandom_range(3) == 0)  step = ~step;
            if ($urandom_range(49) == 0) speed = 2'($urandom_range(3));
            grid_changed = ($urandom_range(3) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/life_ctrl.md
LIFE_CTRL -- requirements
Module: life_ctrl

Interface
REQ-001 Parameter TICK_BASE, default 50_000_000, sets the clock cycles per generation at speed 0.
REQ-002 Parameter LOAD_CYCLES, default 1, sets the number of cycles load is held high per pattern load.
REQ-003 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-low reset (asserted when 0).
REQ-005 Port load_req, input, 1: level input; a rising edge requests a pattern load.
REQ-006 Port run, input, 1: level input; 1 = free-run, 0 = pause.
REQ-007 Port step, input, 1: level input; a rising edge requests one generation while paused.
REQ-008 Port speed, input, 2: selects the generation period.
REQ-009 Port grid_changed, input, 1: from the cell array; 1 if any cell changed on the last generation.
REQ-010 Port load, output, 1: load strobe broadcast to every cell.
REQ-011 Port gen_en, output, 1: one-cycle pulse that advances the cell array by one generation.
REQ-012 Port gen_count, output, 16: number of generations since the last load.
REQ-013 Port state, output, 2: FSM state, encoded IDLE=0, LOAD=1, RUN=2, PAUSE=3.
REQ-014 Port stable, output, 1: pattern-stable flag.

Function
REQ-015 The rising edges of load_req and step SHALL be detected against the previous-cycle sample; the edge is acted on in the cycle after it is sampled.
REQ-016 The FSM SHALL have exactly four states: IDLE, LOAD, RUN, PAUSE.
REQ-017 A load_req edge in any state SHALL enter LOAD, abort any pending tick, and clear the divider; it has highest priority.
REQ-018 In LOAD: load=1 for exactly LOAD_CYCLES cycles; gen_count cleared to 0; stable cleared; next state PAUSE.
REQ-019 A load_req edge during LOAD SHALL restart the LOAD_CYCLES count.
REQ-020 In IDLE: outputs are quiescent; run and step are ignored; only a load_req edge leaves IDLE.
REQ-021 In PAUSE: run=1 enters RUN next cycle with the divider at 0; otherwise a step edge gives gen_en=1 for one cycle and gen_count+1, staying in PAUSE.
REQ-022 In RUN: the divider counts from 0; at terminal count P-1, gen_en=1 for one cycle, gen_count+1, and the divider returns to 0.
REQ-023 Period P SHALL be max(1, TICK_BASE >> (2*speed)); P=1 gives gen_en high every cycle.
REQ-024 In RUN: run=0 enters PAUSE next cycle and clears the divider; step edges are ignored.
REQ-025 Any change of speed SHALL clear the divider; the new period applies immediately.
REQ-026 load and gen_en SHALL never be high in the same cycle.
REQ-027 gen_count SHALL wrap from 0xFFFF to 0x0000 with no flag.

Reset
REQ-028 While reset=0 at a clock edge: state=IDLE, load=0, gen_en=0, gen_count=0, stable=0, divider=0, edge-detector history=0.
REQ-029 Reset mid-LOAD or mid-RUN SHALL abort at once; no further load or gen_en pulse is issued.

Configuration
REQ-030 Macro LIFE_STILL_DETECT_EN defined: grid_changed is sampled on the cycle after each gen_en; if it is 0, then stable=1 and RUN moves to PAUSE; stable clears on load or on the next gen_en.
REQ-031 Macro LIFE_STILL_DETECT_EN undefined: grid_changed is ignored and stable is tied to 0.

Structure
REQ-032 Package life_pkg SHALL hold the state enum typedef, the speed encoding, the default TICK_BASE and LOAD_CYCLES, and the gen_count width.
REQ-033 A rising-edge sub-module, edge_detect, SHALL be instantiated once for load_req and once for step.

Verification (TICK_BASE=16, LOAD_CYCLES=2)
REQ-034 Stimulus: release reset, then a load_req edge. Response: state 0->1; load high exactly 2 cycles; state=3; gen_count=0.
REQ-035 Stimulus: in PAUSE, three step edges. Response: three single-cycle gen_en pulses; gen_count=3; step held high gives no extra pulse.
REQ-036 Stimulus: run=1 with speed=0, then speed=1. Response: gen_en every 16 cycles, then every 4 cycles after the divider clears; speed=2 or 3 gives gen_en every cycle.
REQ-037 Stimulus: load_req edge in the same cycle as a RUN terminal count. Response: no gen_en; load asserted; gen_count=0.
REQ-038 Stimulus: preload gen_count=0xFFFF via 65535 steps, then one more step. Response: gen_count=0x0000.
REQ-039 Stimulus (macro on): RUN with grid_changed=0 after a gen_en. Response: stable=1; state=PAUSE; no further gen_en. Stimulus (macro off): same input. Response: RUN continues; stable=0.
